// File: rtl/uart_fifo_core.sv
// Full-duplex UART with shared baud tick, 16x-oversampled receiver and
// first-word-fall-through TX/RX FIFOs with sticky line-error flags.
module uart_fifo_core #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 163,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic                 o_tx,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_wr,
  output logic                 o_tx_full,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_empty,
  input  logic                 i_rx_rd,
  input  logic                 i_err_clr,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_overrun
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam int         CW        = $clog2(BAUD_DIV + 1);
  localparam logic       PAR_EN    = (PARITY != 0);
  localparam logic       PAR_ODD   = (PARITY == 1);
  localparam logic [4:0] STOP_LAST = 5'(16 * STOP_BITS - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- baud tick ----------------
  logic [CW-1:0] baud_q;
  logic          tick;

  assign tick = (baud_q == CW'(BAUD_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) baud_q <= '0;
    else          baud_q <= tick ? '0 : baud_q + CW'(1);
  end

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] txf_mem [FIFO_DEPTH];
  logic [AW:0]          txf_wr_q, txf_rd_q;
  logic                 txf_full, txf_empty, txf_push, txf_pop;
  logic [DATA_BITS-1:0] txf_head;
  state_e               tx_state_q;

  assign txf_empty = (txf_wr_q == txf_rd_q);
  assign txf_full  = (txf_wr_q[AW] != txf_rd_q[AW]) &&
                     (txf_wr_q[AW-1:0] == txf_rd_q[AW-1:0]);
  assign txf_push  = i_tx_wr && !txf_full;
  assign txf_pop   = tick && (tx_state_q == S_IDLE) && !txf_empty;
  assign txf_head  = txf_mem[txf_rd_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      txf_wr_q <= '0;
      txf_rd_q <= '0;
    end else begin
      if (txf_push) txf_wr_q <= txf_wr_q + (AW+1)'(1);
      if (txf_pop)  txf_rd_q <= txf_rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (txf_push) txf_mem[txf_wr_q[AW-1:0]] <= i_tx_data;
  end

  // ---------------- TX FSM ----------------
  logic [4:0]           tx_tcnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_q <= S_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tick) begin
      case (tx_state_q)
        S_IDLE: begin
          if (!txf_empty) begin
            tx_shift_q <= txf_head;
            tx_par_q   <= (^txf_head) ^ PAR_ODD;
            tx_q       <= 1'b0;
            tx_tcnt_q  <= '0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_tcnt_q == 5'd15) begin
            tx_q       <= tx_shift_q[0];
            tx_tcnt_q  <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= S_DATA;
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        S_DATA: begin
          if (tx_tcnt_q == 5'd15) begin
            tx_tcnt_q <= '0;
            if (tx_bit_q == LAST_BIT) begin
              if (PAR_EN) begin
                tx_q       <= tx_par_q;
                tx_state_q <= S_PARITY;
              end else begin
                tx_q       <= 1'b1;
                tx_state_q <= S_STOP;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        S_PARITY: begin
          if (tx_tcnt_q == 5'd15) begin
            tx_q       <= 1'b1;
            tx_tcnt_q  <= '0;
            tx_state_q <= S_STOP;
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        S_STOP: begin
          if (tx_tcnt_q == STOP_LAST) begin
            tx_tcnt_q  <= '0;
            tx_state_q <= S_IDLE;
          end else begin
            tx_tcnt_q <= tx_tcnt_q + 5'd1;
          end
        end
        default: begin
          tx_q       <= 1'b1;
          tx_state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX synchroniser + FSM ----------------
  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  state_e               rx_state_q;
  logic [3:0]           rx_tcnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_bad_q;
  logic                 rx_centre, rx_stop_sample, rx_par_bad;
  logic                 rx_push, frame_err_set, parity_err_set, overrun_set;

  assign rx_s           = rx_sync_q[1];
  assign rx_centre      = tick && (rx_tcnt_q == 4'd15);
  assign rx_stop_sample = rx_centre && (rx_state_q == S_STOP);
  assign rx_par_bad     = rx_s != ((^rx_shift_q) ^ PAR_ODD);
  assign parity_err_set = rx_centre && (rx_state_q == S_PARITY) && rx_par_bad;
  assign frame_err_set  = rx_stop_sample && !rx_s;
  assign rx_push        = rx_stop_sample && rx_s && !rx_bad_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rx_sync_q <= 2'b11;
    else          rx_sync_q <= {rx_sync_q[0], i_rx};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_bad_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        S_IDLE: begin
          if (!rx_s) begin
            rx_tcnt_q  <= '0;
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          // Half-bit resample rejects short low glitches on the line.
          if (tick) begin
            if (rx_tcnt_q == 4'd7) begin
              rx_tcnt_q  <= '0;
              rx_bit_q   <= '0;
              rx_bad_q   <= 1'b0;
              rx_state_q <= rx_s ? S_IDLE : S_DATA;
            end else begin
              rx_tcnt_q <= rx_tcnt_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_centre) begin
              rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bit_q == LAST_BIT) rx_state_q <= PAR_EN ? S_PARITY : S_STOP;
              else                      rx_bit_q   <= rx_bit_q + 3'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_centre) begin
              rx_bad_q   <= rx_par_bad;
              rx_state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            rx_tcnt_q <= rx_tcnt_q + 4'd1;
            if (rx_centre) rx_state_q <= S_IDLE;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rxf_mem [FIFO_DEPTH];
  logic [AW:0]          rxf_wr_q, rxf_rd_q;
  logic                 rxf_full, rxf_empty, rxf_pop, rxf_wr;

  assign rxf_empty   = (rxf_wr_q == rxf_rd_q);
  assign rxf_full    = (rxf_wr_q[AW] != rxf_rd_q[AW]) &&
                       (rxf_wr_q[AW-1:0] == rxf_rd_q[AW-1:0]);
  assign rxf_pop     = i_rx_rd && !rxf_empty;
  assign rxf_wr      = rx_push && (!rxf_full || rxf_pop);
  assign overrun_set = rx_push && rxf_full && !rxf_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxf_wr_q <= '0;
      rxf_rd_q <= '0;
    end else begin
      if (rxf_wr)  rxf_wr_q <= rxf_wr_q + (AW+1)'(1);
      if (rxf_pop) rxf_rd_q <= rxf_rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (rxf_wr) rxf_mem[rxf_wr_q[AW-1:0]] <= rx_shift_q;
  end

  // ---------------- sticky flags: set beats clear ----------------
  logic frame_err_q, parity_err_q, overrun_q;
  logic frame_err_d, parity_err_d, overrun_d;

  assign frame_err_d  = frame_err_set  | (frame_err_q  & ~i_err_clr);
  assign parity_err_d = parity_err_set | (parity_err_q & ~i_err_clr);
  assign overrun_d    = overrun_set    | (overrun_q    & ~i_err_clr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_tx            = tx_q;
  assign o_tx_full       = txf_full;
  assign o_tx_busy       = !txf_empty || (tx_state_q != S_IDLE);
  assign o_rx_empty      = rxf_empty;
  assign o_rx_data       = rxf_empty ? '0 : rxf_mem[rxf_rd_q[AW-1:0]];
  assign o_rx_frame_err  = frame_err_q;
  assign o_rx_parity_err = parity_err_q;
  assign o_rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: BAUD_DIV=4, 8 data bits, even parity,
// two stop bits, 4-deep FIFOs. One bit on the line is 64 clock cycles.
module tb_uart_fifo_core;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_drv, loop_en, rx_line;
  logic       tx, tx_full, tx_busy, rx_empty;
  logic       fe, pe, ov;
  logic [7:0] tx_data, rx_data;
  logic       tx_wr, rx_rd, err_clr;
  int         n_vec = 0;
  int         n_err = 0;
  bit         clr_hit, pop_hit;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx : rx_drv;

  uart_fifo_core #(
    .DATA_BITS(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_line), .o_tx(tx),
    .i_tx_data(tx_data), .i_tx_wr(tx_wr), .o_tx_full(tx_full), .o_tx_busy(tx_busy),
    .o_rx_data(rx_data), .o_rx_empty(rx_empty), .i_rx_rd(rx_rd),
    .i_err_clr(err_clr), .o_rx_frame_err(fe), .o_rx_parity_err(pe),
    .o_rx_overrun(ov)
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // mode 1: pop the RX FIFO in the push cycle; mode 2: clear flags in the frame-error cycle
  task automatic drive_bit(input logic b, input int cycles, input int mode);
    rx_drv = b;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rx_rd   = (mode == 1) && dut.rx_push;
      err_clr = (mode == 2) && dut.frame_err_set;
      if (rx_rd)   pop_hit = 1'b1;
      if (err_clr) clr_hit = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_ok,
                            input int mode);
    drive_bit(1'b0, BIT, mode);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT, mode);
    drive_bit(par, BIT, mode);
    if (stop_ok) drive_bit(1'b1, BIT, mode);
    else         drive_bit(1'b0, 48, mode);
    drive_bit(1'b1, BIT, mode);
    rx_rd   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic wait_rx(input int maxc, output bit ok);
    int c = 0;
    while (rx_empty && c < maxc) begin
      @(negedge clk);
      c++;
    end
    ok = !rx_empty;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    tx_data = '0; tx_wr = 1'b0; rx_rd = 1'b0; err_clr = 1'b0;
    idle(3);
    n_vec++;
    if ({tx, tx_full, tx_busy, rx_empty, rx_data, fe, pe, ov} !== {4'b1001, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b",
               {tx, tx_full, tx_busy, rx_empty, rx_data, fe, pe, ov}, {4'b1001, 8'h00, 3'b000});
    end
    rst_n = 1'b1;
    idle(10);
    n_vec++;
    if ({tx, tx_full, tx_busy, rx_empty, fe, pe, ov} !== 7'b1001000) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b expected %b",
               {tx, tx_full, tx_busy, rx_empty, fe, pe, ov}, 7'b1001000);
    end
  endtask

  task automatic test_loopback();
    int lat = 0;
    int cnt = 0;
    bit ok;
    loop_en = 1'b1;
    tx_data = 8'hA5; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0; lat = 1;
    while (tx !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat > 6) begin
      n_err++;
      $display("FAIL start_latency: got %0d cycles required <= 6", lat);
    end
    tx_data = 8'h3C; tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    wait_rx(1000, ok);
    n_vec++;
    if (!ok || rx_data !== 8'hA5 || {fe, pe, ov} !== 3'b000) begin
      n_err++;
      $display("FAIL loop_byte0: got ok=%0d data=%h flags=%b expected data=a5 flags=000",
               ok, rx_data, {fe, pe, ov});
    end
    pop_rx();
    wait_rx(1000, ok);
    n_vec++;
    if (!ok || rx_data !== 8'h3C || tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL loop_byte1: got ok=%0d data=%h busy=%b expected data=3c busy=1",
               ok, rx_data, tx_busy);
    end
    pop_rx();
    while (tx_busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    n_vec++;
    if (cnt < 70 || cnt > 120 || tx !== 1'b1 || {fe, pe, ov} !== 3'b000) begin
      n_err++;
      $display("FAIL busy_drop: got %0d cycles tx=%b flags=%b expected 70..120 tx=1 flags=000",
               cnt, tx, {fe, pe, ov});
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp_q[$];
    int dropped = 0;
    int got = 0;
    int cyc = 0;
    loop_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'h10 + 8'(i);
      tx_wr   = 1'b1;
      if (!tx_full) exp_q.push_back(tx_data);
      else          dropped++;
      @(negedge clk);
    end
    tx_wr = 1'b0;
    n_vec++;
    if (dropped < 1 || exp_q.size() < 4 || exp_q.size() > 5) begin
      n_err++;
      $display("FAIL full_accept: got accepted=%0d dropped=%0d expected 4..5 accepted",
               exp_q.size(), dropped);
    end
    while (got < exp_q.size() && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (rx_rd) rx_rd = 1'b0;
      else if (!rx_empty) begin
        n_vec++;
        if (rx_data !== exp_q[got]) begin
          n_err++;
          $display("FAIL full_order[%0d]: got %h expected %h", got, rx_data, exp_q[got]);
        end
        got++;
        rx_rd = 1'b1;
      end
    end
    @(negedge clk);
    rx_rd = 1'b0;
    n_vec++;
    if (got != exp_q.size()) begin
      n_err++;
      $display("FAIL full_timeout: got %0d bytes expected %0d", got, exp_q.size());
    end
    idle(900);
    n_vec++;
    if ({rx_empty, ov, tx_busy} !== 3'b100) begin
      n_err++;
      $display("FAIL full_tail: got empty/ov/busy=%b expected 100", {rx_empty, ov, tx_busy});
    end
  endtask

  task automatic test_parity_err();
    loop_en = 1'b0;
    send_frame(8'h55, 1'b1, 1'b1, 0);
    n_vec++;
    if ({pe, fe, rx_empty} !== 3'b101) begin
      n_err++;
      $display("FAIL parity_set: got pe/fe/empty=%b expected 101", {pe, fe, rx_empty});
    end
    pulse_clr();
    n_vec++;
    if (pe !== 1'b0) begin
      n_err++;
      $display("FAIL parity_clr: got %b expected 0", pe);
    end
    send_frame(8'h12, 1'b0, 1'b1, 0);
    n_vec++;
    if (rx_empty !== 1'b0 || rx_data !== 8'h12 || {fe, pe, ov} !== 3'b000) begin
      n_err++;
      $display("FAIL parity_next: got empty=%b data=%h flags=%b expected 0 12 000",
               rx_empty, rx_data, {fe, pe, ov});
    end
    pop_rx();
  endtask

  task automatic test_frame_err();
    send_frame(8'h81, 1'b0, 1'b0, 0);
    n_vec++;
    if ({fe, pe, rx_empty} !== 3'b101) begin
      n_err++;
      $display("FAIL frame_set: got fe/pe/empty=%b expected 101", {fe, pe, rx_empty});
    end
    pulse_clr();
    n_vec++;
    if (fe !== 1'b0) begin
      n_err++;
      $display("FAIL frame_clr: got %b expected 0", fe);
    end
    clr_hit = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 2);
    n_vec++;
    if (fe !== 1'b1 || clr_hit !== 1'b1 || rx_empty !== 1'b1) begin
      n_err++;
      $display("FAIL frame_set_wins: got fe=%b clr_hit=%b empty=%b expected 1 1 1",
               fe, clr_hit, rx_empty);
    end
    pulse_clr();
  endtask

  task automatic test_overrun();
    logic [7:0] d   [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic       par [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp [4] = '{8'h02, 8'h03, 8'h04, 8'h06};
    for (int i = 0; i < 5; i++) send_frame(d[i], par[i], 1'b1, 0);
    n_vec++;
    if ({ov, rx_empty, rx_data} !== {2'b10, 8'h01}) begin
      n_err++;
      $display("FAIL overrun_set: got ov/empty/head=%b/%b/%h expected 1/0/01", ov, rx_empty, rx_data);
    end
    pulse_clr();
    pop_hit = 1'b0;
    send_frame(8'h06, 1'b0, 1'b1, 1);
    n_vec++;
    if (ov !== 1'b0 || pop_hit !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_pop_same_cycle: got ov=%b pop_hit=%b expected 0 1", ov, pop_hit);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rx_empty !== 1'b0 || rx_data !== exp[i]) begin
        n_err++;
        $display("FAIL overrun_order[%0d]: got empty=%b data=%h expected 0 %h",
                 i, rx_empty, rx_data, exp[i]);
      end
      pop_rx();
    end
    n_vec++;
    if (rx_empty !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_drain: got empty=%b expected 1", rx_empty);
    end
  endtask

  task automatic test_glitch_reset();
    rx_drv = 1'b0;
    idle(16);
    rx_drv = 1'b1;
    idle(200);
    n_vec++;
    if ({rx_empty, fe, pe, ov} !== 4'b1000) begin
      n_err++;
      $display("FAIL glitch: got empty/fe/pe/ov=%b expected 1000", {rx_empty, fe, pe, ov});
    end
    send_frame(8'h77, 1'b0, 1'b1, 0);
    send_frame(8'h55, 1'b1, 1'b1, 0);
    n_vec++;
    if ({rx_empty, rx_data, pe} !== {1'b0, 8'h77, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset_rx: got empty=%b data=%h pe=%b expected 0 77 1", rx_empty, rx_data, pe);
    end
    tx_data = 8'h00;
    tx_wr   = 1'b1;
    idle(3);
    tx_wr   = 1'b0;
    idle(200);
    n_vec++;
    if ({tx, tx_busy} !== 2'b01) begin
      n_err++;
      $display("FAIL mid_frame: got tx/busy=%b expected 01", {tx, tx_busy});
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({tx, tx_full, tx_busy, rx_empty, rx_data, fe, pe, ov} !== {4'b1001, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b",
               {tx, tx_full, tx_busy, rx_empty, rx_data, fe, pe, ov}, {4'b1001, 8'h00, 3'b000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    n_vec++;
    if ({tx, tx_busy, rx_empty} !== 3'b101) begin
      n_err++;
      $display("FAIL after_reset: got tx/busy/empty=%b expected 101", {tx, tx_busy, rx_empty});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback();
    test_tx_full();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_glitch_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
